// File: rtl/reg_bank.sv
// Register bank with per-register busy (pending-write) scoreboard.
// Two combinational read ports, one write port, one issue port that marks a
// destination register as pending until it is written back.
// Register 0 is hardwired to zero and can never become busy.
// Optional feature macro: REG_BANK_BYPASS_EN -- forwards same-cycle write data
// (and clears the busy indication) on a read address match.
module reg_bank #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              busy_rs,
   output logic              busy_rt,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [ADDR_W:0]   pend_q;
   logic [ADDR_W:0]   pend_d;

   // Next busy vector: writeback clears, issue sets afterwards so issue wins on a tie.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (issue_en && (issue_addr != '0)) begin
         busy_d[issue_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
      pend_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         pend_d = pend_d + {{ADDR_W{1'b0}}, busy_d[i]};
      end
   end

   // Storage, busy bits and pending count; reset discards everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
         pend_q <= '0;
      end else begin
         if (wr_en && (wr_addr != '0)) begin
            mem_q[wr_addr] <= wr_data;
         end
         busy_q <= busy_d;
         pend_q <= pend_d;
      end
   end

   // Zero-latency reads and busy lookups, with optional same-cycle forwarding.
   always_comb begin
      rs_data = (rs_addr == '0) ? '0 : mem_q[rs_addr];
      rt_data = (rt_addr == '0) ? '0 : mem_q[rt_addr];
      busy_rs = busy_q[rs_addr];
      busy_rt = busy_q[rt_addr];
`ifdef REG_BANK_BYPASS_EN
      // Gated by reset so outputs stay zero while reset is held.
      if (!reset && wr_en && (wr_addr != '0)) begin
         if (wr_addr == rs_addr) begin
            rs_data = wr_data;
            busy_rs = 1'b0;
         end
         if (wr_addr == rt_addr) begin
            rt_data = wr_data;
            busy_rt = 1'b0;
         end
      end
`endif
   end

   assign pend_cnt = pend_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, hand-written
// bypass and mid-cycle reset sequences, then randomized traffic against a
// behavioural model of the register file and its pending set.
module tb_reg_bank;

`ifdef REG_BANK_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_addr, rt_addr, wr_addr, issue_addr;
   logic [31:0] rs_data, rt_data, wr_data;
   logic        wr_en, issue_en;
   logic        busy_rs, busy_rt;
   logic [5:0]  pend_cnt;

   int n_cmp = 0;
   int n_err = 0;

   reg_bank dut (
      .clk       (clk),
      .reset     (reset),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .issue_en  (issue_en),
      .issue_addr(issue_addr),
      .busy_rs   (busy_rs),
      .busy_rt   (busy_rt),
      .pend_cnt  (pend_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic [31:0] wr_data;
      logic        issue_en;
      logic [4:0]  issue_addr;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [31:0] exp_rs;
      logic [31:0] exp_rt;
      logic        exp_brs;
      logic        exp_brt;
      logic [5:0]  exp_pend;
   } vec_t;

   vec_t vecs[11];

   // Behavioural model: register contents and set of pending registers.
   logic [31:0] m_mem [32];
   bit          m_pend [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_pending();
      int c = 0;
      foreach (m_pend[i]) if (m_pend[i]) c++;
      return c;
   endfunction

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      issue_en = 1'b0; issue_addr = '0;
   endtask

   function automatic logic [4:0] pick_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      // Directed table: row applied for one edge, outputs checked after it.
      vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  5'd5, 5'd0, 32'h0,        32'h0,      1'b0, 1'b0, 6'd0};
      vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  5'd5, 5'd0, 32'hDEADBEEF, 32'h0,      1'b0, 1'b0, 6'd0};
      vecs[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0,  5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7,  5'd7, 5'd9, 32'h0,        32'h0,      1'b1, 1'b0, 6'd1};
      vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9,  5'd7, 5'd9, 32'h0,        32'h0,      1'b1, 1'b1, 6'd2};
      vecs[5]  = '{1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0,  5'd7, 5'd9, 32'h77,       32'h0,      1'b0, 1'b1, 6'd1};
      vecs[6]  = '{1'b1, 5'd3, 32'h0000A5A5, 1'b1, 5'd3,  5'd3, 5'd9, 32'hA5A5,     32'h0,      1'b1, 1'b1, 6'd2};
      vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9,  5'd3, 5'd9, 32'hA5A5,     32'h0,      1'b1, 1'b1, 6'd2};
      vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  5'd0, 5'd3, 32'h0,        32'hA5A5,   1'b0, 1'b1, 6'd2};
      vecs[9]  = '{1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0,  5'd9, 5'd3, 32'h99,       32'hA5A5,   1'b0, 1'b1, 6'd1};
      vecs[10] = '{1'b1, 5'd4, 32'h00001111, 1'b0, 5'd0,  5'd4, 5'd4, 32'h1111,     32'h1111,   1'b0, 1'b0, 6'd1};

      idle_inputs();
      rs_addr = 5'd5; rt_addr = 5'd0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk); #1;

      // Reset state.
      chk("rst_rs_data", rs_data, 32'h0);
      chk("rst_pend", {26'h0, pend_cnt}, 32'h0);

      foreach (vecs[i]) begin
         wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
         issue_en = vecs[i].issue_en; issue_addr = vecs[i].issue_addr;
         rs_addr = vecs[i].rs_addr; rt_addr = vecs[i].rt_addr;
         @(posedge clk); #1;
         idle_inputs();
         #1;
         chk($sformatf("v%0d_rs_data", i), rs_data, vecs[i].exp_rs);
         chk($sformatf("v%0d_rt_data", i), rt_data, vecs[i].exp_rt);
         chk($sformatf("v%0d_busy_rs", i), {31'h0, busy_rs}, {31'h0, vecs[i].exp_brs});
         chk($sformatf("v%0d_busy_rt", i), {31'h0, busy_rt}, {31'h0, vecs[i].exp_brt});
         chk($sformatf("v%0d_pend", i), {26'h0, pend_cnt}, {26'h0, vecs[i].exp_pend});
      end

      // Same-cycle write and read of a busy register: forwarding vs old value.
      issue_en = 1'b1; issue_addr = 5'd4;
      @(posedge clk); #1;
      idle_inputs();
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h12345678;
      rs_addr = 5'd4; rt_addr = 5'd3;
      #1;
      chk("byp_rs_data", rs_data, BYP ? 32'h12345678 : 32'h00001111);
      chk("byp_busy_rs", {31'h0, busy_rs}, BYP ? 32'h0 : 32'h1);
      chk("byp_rt_data", rt_data, 32'h0000A5A5);
      chk("byp_pend_before", {26'h0, pend_cnt}, 32'd2);
      @(posedge clk); #1;
      idle_inputs();
      #1;
      chk("byp_after_data", rs_data, 32'h12345678);
      chk("byp_after_busy", {31'h0, busy_rs}, 32'h0);
      chk("byp_after_pend", {26'h0, pend_cnt}, 32'd1);

      // Three more busy registers, then reset asserted mid-cycle.
      for (int a = 10; a < 13; a++) begin
         issue_en = 1'b1; issue_addr = 5'(a);
         @(posedge clk); #1;
      end
      idle_inputs();
      rs_addr = 5'd3; rt_addr = 5'd10;
      #1;
      chk("pre_rst_pend", {26'h0, pend_cnt}, 32'd4);
      chk("pre_rst_busy_rt", {31'h0, busy_rt}, 32'h1);
      reset = 1'b1;
      #1;
      chk("mid_rst_rs_data", rs_data, 32'h0);
      chk("mid_rst_busy_rt", {31'h0, busy_rt}, 32'h0);
      chk("mid_rst_pend", {26'h0, pend_cnt}, 32'h0);
      // Strobes during reset must be ignored.
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D;
      issue_en = 1'b1; issue_addr = 5'd6;
      rs_addr = 5'd3; rt_addr = 5'd6;
      #1;
      chk("rst_wr_rs_data", rs_data, 32'h0);
      @(posedge clk); #2;
      idle_inputs();
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_pend", {26'h0, pend_cnt}, 32'h0);
      chk("post_rst_rs_data", rs_data, 32'h0);
      chk("post_rst_busy_rt", {31'h0, busy_rt}, 32'h0);

      // Randomized traffic against the model (state is all-zero after reset).
      foreach (m_mem[i]) begin
         m_mem[i] = '0;
         m_pend[i] = 1'b0;
      end
      for (int cyc = 0; cyc < 2000; cyc++) begin
         logic [31:0] e_rs, e_rt;
         bit          e_brs, e_brt;
         wr_en = ($urandom_range(0, 2) == 0);
         wr_addr = pick_addr();
         wr_data = $urandom;
         issue_en = ($urandom_range(0, 2) == 0);
         issue_addr = pick_addr();
         rs_addr = pick_addr();
         rt_addr = pick_addr();
         #3;
         e_rs = (rs_addr == 0) ? 32'h0 : m_mem[rs_addr];
         e_rt = (rt_addr == 0) ? 32'h0 : m_mem[rt_addr];
         e_brs = m_pend[rs_addr];
         e_brt = m_pend[rt_addr];
         if (BYP && wr_en && wr_addr != 0) begin
            if (wr_addr == rs_addr) begin e_rs = wr_data; e_brs = 1'b0; end
            if (wr_addr == rt_addr) begin e_rt = wr_data; e_brt = 1'b0; end
         end
         chk("rnd_rs_data", rs_data, e_rs);
         chk("rnd_rt_data", rt_data, e_rt);
         chk("rnd_busy_rs", {31'h0, busy_rs}, {31'h0, e_brs});
         chk("rnd_busy_rt", {31'h0, busy_rt}, {31'h0, e_brt});
         chk("rnd_pend", {26'h0, pend_cnt}, 32'(model_pending()));
         @(posedge clk);
         // A writeback retires the pending entry; a new issue re-enters it.
         if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
         if (wr_en) m_pend[wr_addr] = 1'b0;
         if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W registers.
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port rs_addr  input  ADDR_W  read port A address.
REQ-006 SHALL provide port rt_addr  input  ADDR_W  read port B address.
REQ-007 SHALL provide port rs_data  output  DATA_W  read port A data.
REQ-008 SHALL provide port rt_data  output  DATA_W  read port B data.
REQ-009 SHALL provide port wr_en  input  1  write strobe.
REQ-010 SHALL provide port wr_addr  input  ADDR_W  write address.
REQ-011 SHALL provide port wr_data  input  DATA_W  write data.
REQ-012 SHALL provide port issue_en  input  1  marks issue_addr as pending a write.
REQ-013 SHALL provide port issue_addr  input  ADDR_W  destination being issued.
REQ-014 SHALL provide port busy_rs  output  1  rs_addr has a pending write.
REQ-015 SHALL provide port busy_rt  output  1  rt_addr has a pending write.
REQ-016 SHALL provide port pend_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-017 SHALL store 2**ADDR_W registers of DATA_W bits plus one busy bit per register.
REQ-018 SHALL read rs_data/rt_data combinationally from storage (zero-cycle latency).
REQ-019 SHALL write wr_data into wr_addr on the rising clk edge when wr_en=1; value visible on reads the cycle after.
REQ-020 SHALL hardwire register 0: reads return 0, writes ignored, busy bit never set.
REQ-021 SHALL set busy[issue_addr] on the clk edge when issue_en=1 and issue_addr!=0.
REQ-022 SHALL clear busy[wr_addr] on the clk edge when wr_en=1, unless cleared and set in the same cycle.
REQ-023 SHALL let issue win when issue_en and wr_en target the same nonzero address in one cycle (busy stays 1, data written).
REQ-024 SHALL allow a write to a non-busy register (no error, busy unaffected).
REQ-025 SHALL drive busy_rs/busy_rt combinationally from busy[rs_addr]/busy[rt_addr], subject to REQ-030.
REQ-026 SHALL keep pend_cnt registered and equal to the popcount of the busy vector after each edge; range 0..2**ADDR_W-1, no wrap possible.
REQ-027 SHALL leave issue of an already-busy register idempotent (pend_cnt unchanged).

Reset
REQ-028 SHALL, while reset=1, asynchronously clear all registers, all busy bits and pend_cnt to 0; rs_data, rt_data, busy_rs, busy_rt read 0.
REQ-029 SHALL ignore wr_en and issue_en on any edge where reset is asserted; reset mid-operation discards all pending state.

Configuration
REQ-030 SHALL, with macro REG_BANK_BYPASS_EN defined, forward wr_data to rs_data/rt_data and force busy_rs/busy_rt to 0 in the same cycle when wr_en=1 and wr_addr equals the read address (nonzero); without the macro, reads return old storage and busy reflects the stored bit until the edge.

Verification
REQ-031 SHALL cover: reset, write 0xDEADBEEF to r5, read rs_addr=5 next cycle -> rs_data=0xDEADBEEF; rt_addr=0 -> rt_data=0.
REQ-032 SHALL cover: wr_en=1 wr_addr=0 wr_data=0xFFFFFFFF -> r0 reads 0, pend_cnt 0.
REQ-033 SHALL cover: issue r7, then r9 -> pend_cnt 1 then 2; busy_rs=1 for rs_addr=7; write r7 -> pend_cnt 1, busy_rs=0.
REQ-034 SHALL cover: same-cycle issue_en and wr_en on r3 -> busy[3]=1, r3 holds new data, pend_cnt +1.
REQ-035 SHALL cover: wr r4=0x12345678 with rs_addr=4 same cycle -> with REG_BANK_BYPASS_EN rs_data=0x12345678, without it old r4 value.
REQ-036 SHALL cover: 3 busy registers, assert reset mid-cycle -> all outputs 0 immediately, pend_cnt 0 after release.
